mac_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined unsigned multiply-accumulate unit (A*B+C) among N_REQ requesters. Each requester presents an operand triple under a valid/ready handshake. The block grants one request per cycle, pushes it through a two-stage stallable MAC pipeline, and returns the result tagged with the requester index. It sits between the per-channel operand sources and the shared result sink.

---
 rtl/mac_arb_pkg.sv | 22 ++
 rtl/mac_arbiter_if.sv | 35 +++
 rtl/mac_pipe.sv | 58 +++++
 rtl/mac_arbiter.sv | 76 +++++++
 tb/tb_mac_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_arb_pkg.sv
// Shared types and defaults for the round-robin MAC arbiter.
// Holds default widths, the index-width helper and the stage-1 bundle.
package mac_arb_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int OUT_WIDTH_DEF = 16;
  localparam int N_REQ_DEF     = 4;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ID_W_DEF = id_w(N_REQ_DEF);

  typedef struct packed {
    logic                   valid;
    logic [ID_W_DEF-1:0]    id;
    logic [2*WIDTH_DEF-1:0] prod;
    logic [WIDTH_DEF-1:0]   c;
  } stage1_t;

endpackage

// File: rtl/mac_arbiter_if.sv
// Requester and result handshake bundle for mac_arbiter.
// master drives operands and res_ready; slave is the arbiter.
interface mac_arbiter_if #(
  parameter int WIDTH     = mac_arb_pkg::WIDTH_DEF,
  parameter int OUT_WIDTH = mac_arb_pkg::OUT_WIDTH_DEF,
  parameter int N_REQ     = mac_arb_pkg::N_REQ_DEF
);

  localparam int ID_W = mac_arb_pkg::id_w(N_REQ);

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic [N_REQ-1:0][WIDTH-1:0] req_c;
  logic                        res_valid;
  logic                        res_ready;
  logic [ID_W-1:0]             res_id;
  logic [OUT_WIDTH-1:0]        res_data;

  modport master (
    output req_valid, req_a, req_b, req_c,
    output res_ready,
    input  req_ready,
    input  res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c,
    input  res_ready,
    output req_ready,
    output res_valid, res_id, res_data
  );

endinterface

// File: rtl/mac_pipe.sv
// Two-stage stallable unsigned A*B+C with requester id passthrough.
// Stage 1 registers the product, stage 2 the wrapped sum.
module mac_pipe
  import mac_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int ID_W      = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [ID_W-1:0]      in_id,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [WIDTH-1:0]     in_c,
  output logic                 out_valid,
  output logic [ID_W-1:0]      out_id,
  output logic [OUT_WIDTH-1:0] out_data
);

  localparam int PW = 2 * WIDTH;

  typedef struct packed {
    logic             valid;
    logic [ID_W-1:0]  id;
    logic [PW-1:0]    prod;
    logic [WIDTH-1:0] c;
  } s1_t;

  s1_t                  s1;
  logic [OUT_WIDTH-1:0] sum;

  assign sum = OUT_WIDTH'(s1.prod) + OUT_WIDTH'(s1.c);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      out_valid <= 1'b0;
      out_id    <= '0;
      out_data  <= '0;
    end else if (en) begin
      s1.valid <= in_valid;
      if (in_valid) begin
        s1.id   <= in_id;
        s1.prod <= PW'(in_a) * PW'(in_b);
        s1.c    <= in_c;
      end
      out_valid <= s1.valid;
      if (s1.valid) begin
        out_id   <= s1.id;
        out_data <= sum;
      end
    end
  end

endmodule

// File: rtl/mac_arbiter.sv
// Round-robin arbiter sharing one pipelined A*B+C unit.
// Grants at most one requester per cycle; results carry the index.
module mac_arbiter
  import mac_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int N_REQ     = N_REQ_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  mac_arbiter_if.slave  bus
);

  localparam int ID_W = id_w(N_REQ);

  logic             en;
  logic             found;
  logic [ID_W-1:0]  ptr;
  logic [ID_W-1:0]  gnt;
  logic [N_REQ-1:0] ready;

  // rst_n gates grants so nothing is accepted while held in reset
  assign en = (!bus.res_valid || bus.res_ready) && rst_n;

  // reverse scan: the last hit is the one closest to ptr
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (bus.req_valid[j]) begin
        found = 1'b1;
        gnt   = ID_W'(j);
      end
    end
    found = found & en;
  end

  always_comb begin
    ready      = '0;
    ready[gnt] = found;
  end

  assign bus.req_ready = ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (gnt == ID_W'(N_REQ - 1)) ? '0
                                       : gnt + ID_W'(1);
    end
  end

  mac_pipe #(
    .WIDTH     (WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .ID_W      (ID_W)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (found),
    .in_id     (gnt),
    .in_a      (bus.req_a[gnt]),
    .in_b      (bus.req_b[gnt]),
    .in_c      (bus.req_c[gnt]),
    .out_valid (bus.res_valid),
    .out_id    (bus.res_id),
    .out_data  (bus.res_data)
  );

endmodule

// File: tb/tb_mac_arbiter.sv
// Scoreboard bench for mac_arbiter: queued expectations, monitor pops.
// A second instance with WIDTH=10 covers the modular-wrap case.
module tb_mac_arbiter;
  import mac_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_arbiter_if #(.WIDTH(8), .OUT_WIDTH(16), .N_REQ(4)) bus();
  mac_arbiter #(.WIDTH(8), .OUT_WIDTH(16), .N_REQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mac_arbiter_if #(.WIDTH(10), .OUT_WIDTH(16), .N_REQ(2)) bw();
  mac_arbiter #(.WIDTH(10), .OUT_WIDTH(16), .N_REQ(2)) dut_w (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bw)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
  } op_t;

  typedef struct packed {
    logic [1:0]  id;
    logic [15:0] data;
  } exp_t;

  op_t  ops [4][16];
  int   rd [4];
  int   wr [4];
  exp_t sb [$];
  int   pop_cyc [$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [3:0] xs;
  int   p0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic enq(input int i, input int a, input int b, input int c);
    ops[i][wr[i]] = '{a: 8'(a), b: 8'(b), c: 8'(c)};
    wr[i] = wr[i] + 1;
  endtask

  task automatic push_exp(input int id, input int data);
    sb.push_back('{id: 2'(id), data: 16'(data)});
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(sb.size()), 0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // requester model: advance on a handshake seen at the previous negedge
  always @(negedge clk) xs = bus.req_valid & bus.req_ready;

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (xs[i]) rd[i] = rd[i] + 1;
      bus.req_valid[i] = rd[i] < wr[i];
      bus.req_a[i] = bus.req_valid[i] ? ops[i][rd[i]].a : 8'd0;
      bus.req_b[i] = bus.req_valid[i] ? ops[i][rd[i]].b : 8'd0;
      bus.req_c[i] = bus.req_valid[i] ? ops[i][rd[i]].c : 8'd0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got id %0d data %0d, none queued",
                 bus.res_id, bus.res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        pop_cyc.push_back(cyc);
        if (bus.res_id !== e.id || bus.res_data !== e.data) begin
          n_fail++;
          $display("FAIL sb_result: got id %0d data %0d expected id %0d data %0d",
                   bus.res_id, bus.res_data, e.id, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    bus.res_ready = 1'b1;
    bw.req_valid  = '0;
    bw.req_a      = '0;
    bw.req_b      = '0;
    bw.req_c      = '0;
    bw.res_ready  = 1'b1;
    rst_n = 1'b0;

    // reset with every requester valid, then round robin
    enq(0, 1, 2, 0);
    enq(0, 1, 2, 0);
    enq(1, 2, 2, 0);
    enq(2, 3, 2, 0);
    enq(3, 4, 2, 0);
    push_exp(0, 2);
    push_exp(1, 4);
    push_exp(2, 6);
    push_exp(3, 8);
    push_exp(0, 2);
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_res_valid", 32'(bus.res_valid), 0);
    chk("rst_res_data", 32'(bus.res_data), 0);
    chk("rst_res_id", 32'(bus.res_id), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("first_grant", 32'(bus.req_ready), 32'h1);
    p0 = pop_cyc.size();
    drain("rr_drain");
    chk("rr_count", 32'(pop_cyc.size() - p0), 5);
    if (pop_cyc.size() >= p0 + 5)
      chk("rr_back2back", 32'(pop_cyc[p0+4] - pop_cyc[p0]), 4);

    // single request, latency and trailing bubble
    @(negedge clk);
    enq(2, 3, 5, 7);
    push_exp(2, 22);
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'h4);
    @(negedge clk);
    chk("single_lat1", 32'(bus.res_valid), 0);
    @(negedge clk);
    chk("single_valid", 32'(bus.res_valid), 1);
    chk("single_id", 32'(bus.res_id), 2);
    @(negedge clk);
    chk("single_bubble", 32'(bus.res_valid), 0);

    // backpressure for three cycles
    @(negedge clk);
    enq(0, 10, 10, 5);
    enq(1, 4, 4, 4);
    enq(0, 7, 3, 1);
    enq(1, 20, 13, 0);
    push_exp(0, 105);
    push_exp(1, 20);
    push_exp(0, 22);
    push_exp(1, 260);
    p0 = pop_cyc.size();
    @(negedge clk);
    chk("bp_grant0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    chk("bp_grant1", 32'(bus.req_ready), 32'h2);
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
      chk("bp_hold_valid", 32'(bus.res_valid), 1);
      chk("bp_hold_id", 32'(bus.res_id), 0);
      chk("bp_hold_data", 32'(bus.res_data), 105);
    end
    @(posedge clk);
    #1 bus.res_ready = 1'b1;
    drain("bp_drain");
    chk("bp_count", 32'(pop_cyc.size() - p0), 4);

    // full-scale operands and C=0
    @(negedge clk);
    enq(3, 255, 255, 255);
    enq(0, 255, 255, 0);
    push_exp(3, 65280);
    push_exp(0, 65025);
    drain("wrap_drain");

    // async reset with two results in flight
    @(posedge clk);
    #1 bus.res_ready = 1'b0;
    @(negedge clk);
    enq(1, 2, 3, 4);
    enq(2, 5, 5, 5);
    repeat (3) @(negedge clk);
    chk("mid_full", 32'(bus.res_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.res_valid), 0);
    chk("mid_rst_data", 32'(bus.res_data), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    bus.res_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("mid_no_stale", 32'(bus.res_valid), 0);
    end

    // 10-bit operands into 16-bit result: sum wraps
    @(negedge clk);
    bw.req_a[0] = 10'd255;
    bw.req_b[0] = 10'd255;
    bw.req_c[0] = 10'd1000;
    bw.req_valid = 2'b01;
    #1 chk("w_ready", 32'(bw.req_ready), 32'h1);
    @(posedge clk);
    #1 bw.req_valid = 2'b00;
    t = 0;
    while (!bw.res_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    chk("w_seen", 32'(bw.res_valid), 1);
    chk("w_id", 32'(bw.res_id), 0);
    chk("w_data", 32'(bw.res_data), 489);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
